aes_inv_key_sched: RTL and testbench



---
 rtl/aes_inv_key_sched.sv | 107 ++++++++++
 tb/tb_aes_inv_key_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: walks round keys backwards from round 10 to round 0,
// one key per request, using an S-box shared with the decipher datapath.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [127:0] key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic [7:0]   rcon,
  output logic         ready
);

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         ready_q, ready_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [7:0]   rcon_half;
  logic [7:0]   inv_rcon;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  // Undo the forward w[i] = w[i-4] ^ w[i-1] chain, then the S-box word.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ new_sboxw ^ {rcon_q, 24'h000000};

  assign sboxw = {p3[23:0], p3[31:24]};

  // Divide by x in GF(2^8): 8'h8d is x^-1 modulo the AES polynomial.
  assign rcon_half = {1'b0, rcon_q[7:1]};
  assign inv_rcon  = rcon_q[0] ? (rcon_half ^ 8'h8d) : rcon_half;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    ready_d     = ready_q;

    if (init) begin
      // init wins in both states, discarding any pending step.
      state_d     = IDLE;
      round_key_d = key;
      round_d     = 4'd10;
      rcon_d      = 8'h36;
      ready_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (next && ready_q && (round_q != 4'd0)) begin
            state_d = STEP;
            ready_d = 1'b0;
          end
        end
        STEP: begin
          state_d     = IDLE;
          round_key_d = {p0, p1, p2, p3};
          round_d     = round_q - 4'd1;
          rcon_d      = inv_rcon;
          ready_d     = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      round_q     <= 4'd0;
      rcon_q      <= 8'h00;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      ready_q     <= ready_d;
    end
  end

  assign round_key = round_key_q;
  assign round     = round_q;
  assign rcon      = rcon_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 AES-128 example key schedule.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic         next;
  logic [127:0] key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic         ready;

  int n_cmp;
  int n_bad;

  logic [127:0] exp_key [0:10];
  logic [7:0]   exp_rcon [0:10];

  aes_inv_key_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .next      (next),
    .key       (key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .round_key (round_key),
    .round     (round),
    .rcon      (rcon),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference S-box built from the GF(2^8) inverse and the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  assign new_sboxw = {sbox(sboxw[31:24]), sbox(sboxw[23:16]),
                      sbox(sboxw[15:8]), sbox(sboxw[7:0])};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [127:0] k, input logic [3:0] r,
                             input logic [7:0] rc, input logic rdy);
    n_cmp++;
    if (round_key !== k || round !== r || rcon !== rc || ready !== rdy) begin
      n_bad++;
      $display("FAIL %s: got key=%h round=%0d rcon=%h ready=%b, want key=%h round=%0d rcon=%h ready=%b",
               name, round_key, round, rcon, ready, k, r, rc, rdy);
    end
  endtask

  task automatic do_init(input logic [127:0] k);
    key  = k;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    check_state("reset", 128'h0, 4'd0, 8'h00, 1'b0);
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
    check_state("reset_next_ignored", 128'h0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic test_init();
    do_init(exp_key[10]);
    check_state("init_load", exp_key[10], 4'd10, 8'h36, 1'b1);
    n_cmp++;
    if (sboxw !== 32'h5c006e57) begin
      n_bad++;
      $display("FAIL init_sboxw: got %h want %h", sboxw, 32'h5c006e57);
    end
  endtask

  task automatic test_walk();
    for (int r = 9; r >= 0; r--) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL walk_busy r%0d: ready got %b want 0", r, ready);
      end
      tick();
      check_state($sformatf("walk_r%0d", r), exp_key[r], r[3:0], exp_rcon[r], 1'b1);
    end
  endtask

  task automatic test_round0_next();
    next = 1'b1;
    tick();
    next = 1'b0;
    check_state("r0_next_busy", exp_key[0], 4'd0, 8'h8d, 1'b1);
    tick();
    check_state("r0_next_after", exp_key[0], 4'd0, 8'h8d, 1'b1);
  endtask

  task automatic test_init_next_same();
    key  = exp_key[10];
    init = 1'b1;
    next = 1'b1;
    tick();
    init = 1'b0;
    next = 1'b0;
    check_state("init_next_load", exp_key[10], 4'd10, 8'h36, 1'b1);
    tick();
    check_state("init_next_nostep", exp_key[10], 4'd10, 8'h36, 1'b1);
  endtask

  task automatic test_init_during_step();
    next = 1'b1;
    tick();
    next = 1'b0;
    key  = exp_key[10];
    init = 1'b1;
    tick();
    init = 1'b0;
    check_state("init_in_step", exp_key[10], 4'd10, 8'h36, 1'b1);
    tick();
    check_state("init_in_step_discard", exp_key[10], 4'd10, 8'h36, 1'b1);
    // A fresh request still works after the discarded step.
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
    check_state("init_in_step_resume", exp_key[9], 4'd9, 8'h1b, 1'b1);
  endtask

  task automatic test_reset_during_step();
    next = 1'b1;
    tick();
    next = 1'b0;
    do_reset();
    check_state("reset_in_step", 128'h0, 4'd0, 8'h00, 1'b0);
    tick();
    check_state("reset_in_step_hold", 128'h0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic test_hold_next();
    do_init(exp_key[10]);
    next = 1'b1;
    tick();
    tick();
    check_state("hold_first", exp_key[9], 4'd9, 8'h1b, 1'b1);
    tick();
    tick();
    check_state("hold_second", exp_key[8], 4'd8, 8'h80, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    next = 1'b0;
    check_state("hold_to_r0", exp_key[0], 4'd0, 8'h8d, 1'b1);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    init    = 1'b0;
    next    = 1'b0;
    key     = 128'h0;

    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    exp_rcon[0]  = 8'h8d;
    exp_rcon[1]  = 8'h01;
    exp_rcon[2]  = 8'h02;
    exp_rcon[3]  = 8'h04;
    exp_rcon[4]  = 8'h08;
    exp_rcon[5]  = 8'h10;
    exp_rcon[6]  = 8'h20;
    exp_rcon[7]  = 8'h40;
    exp_rcon[8]  = 8'h80;
    exp_rcon[9]  = 8'h1b;
    exp_rcon[10] = 8'h36;

    @(negedge clk);
    test_reset();
    test_init();
    test_walk();
    test_round0_next();
    test_init_next_same();
    test_init_during_step();
    test_reset_during_step();
    test_hold_next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
